// File: rtl/seg7_capture_decoder.sv
// Recovers a hex digit from an active-low 7-segment pattern once it has held for STABLE_CYCLES enabled samples.
// Outputs are registered, so a lock shows STABLE_CYCLES-1 edges after first sample; no backpressure, and sample_en=0 freezes all state.
module seg7_capture_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sample_en,
   input  logic [6:0]       seg_in,
   output logic [3:0]       value,
   output logic             valid,
   output logic             error,
   output logic             changed,
   output logic [CNT_W-1:0] change_count
);

   typedef enum logic [1:0] {SETTLE, LOCKED, BAD} state_t;

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   state_t           state, state_n;
   logic [6:0]       held, held_n;
   logic [3:0]       stable_cnt, stable_cnt_n;
   logic             first_lock, first_lock_n;
   logic [3:0]       value_n;
   logic             valid_n, error_n, changed_n;
   logic [CNT_W-1:0] count_n;
   logic [3:0]       dec;
   logic             legal;

   always_comb begin
      dec   = 4'h0;
      legal = 1'b1;
      case (seg_in)
         7'h40: dec = 4'h0;
         7'h79: dec = 4'h1;
         7'h24: dec = 4'h2;
         7'h30: dec = 4'h3;
         7'h19: dec = 4'h4;
         7'h12: dec = 4'h5;
         7'h02: dec = 4'h6;
         7'h78: dec = 4'h7;
         7'h00: dec = 4'h8;
         7'h10: dec = 4'h9;
         7'h08: dec = 4'hA;
         7'h03: dec = 4'hB;
         7'h46: dec = 4'hC;
         7'h21: dec = 4'hD;
         7'h06: dec = 4'hE;
         7'h0E: dec = 4'hF;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_n      = state;
      held_n       = held;
      stable_cnt_n = stable_cnt;
      first_lock_n = first_lock;
      value_n      = value;
      valid_n      = valid;
      error_n      = error;
      changed_n    = 1'b0;
      count_n      = change_count;
      if (sample_en) begin
         if (seg_in != held) begin
            held_n       = seg_in;
            stable_cnt_n = 4'd1;
            state_n      = SETTLE;
            valid_n      = 1'b0;
            error_n      = 1'b0;
         end else if (stable_cnt < STABLE) begin
            stable_cnt_n = stable_cnt + 4'd1;
         end
         // A fresh pattern can settle on its very first sample when STABLE_CYCLES is 1.
         if (state_n == SETTLE && stable_cnt_n == STABLE) begin
            if (legal) begin
               state_n      = LOCKED;
               valid_n      = 1'b1;
               value_n      = dec;
               first_lock_n = 1'b0;
               if (first_lock || dec != value) begin
                  changed_n = 1'b1;
                  count_n   = change_count + 1'b1;
               end
            end else begin
               state_n = BAD;
               error_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= SETTLE;
         held         <= 7'h7F;
         stable_cnt   <= 4'd0;
         first_lock   <= 1'b1;
         value        <= 4'h0;
         valid        <= 1'b0;
         error        <= 1'b0;
         changed      <= 1'b0;
         change_count <= '0;
      end else begin
         state        <= state_n;
         held         <= held_n;
         stable_cnt   <= stable_cnt_n;
         first_lock   <= first_lock_n;
         value        <= value_n;
         valid        <= valid_n;
         error        <= error_n;
         changed      <= changed_n;
         change_count <= count_n;
      end
   end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: a run-length model checks two instances (4-sample and 1-sample filters) every cycle.
module tb_seg7_capture_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sample_en = 1'b0;
   logic [6:0] seg_in = 7'h7F;

   logic [3:0] value0, value1;
   logic       valid0, valid1, error0, error1, changed0, changed1;
   logic [7:0] count0, count1;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   seg7_capture_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut0 (
      .clock(clock), .reset(reset), .sample_en(sample_en), .seg_in(seg_in),
      .value(value0), .valid(valid0), .error(error0), .changed(changed0), .change_count(count0));

   seg7_capture_decoder #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
      .clock(clock), .reset(reset), .sample_en(sample_en), .seg_in(seg_in),
      .value(value1), .valid(valid1), .error(error1), .changed(changed1), .change_count(count1));

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Model: track how many consecutive enabled samples the current pattern has had.
   int         need [2] = '{4, 1};
   logic [6:0] m_last [2];
   int         m_run  [2];
   logic       m_first[2];
   int         m_val  [2];
   bit         m_vld  [2];
   bit         m_err  [2];
   bit         m_chg  [2];
   int         m_cnt  [2];
   bit         armed = 1'b0;

   function automatic int glyph_index(input logic [6:0] s);
      for (int g = 0; g < 16; g++)
         if (glyph[g] == s) return g;
      return -1;
   endfunction

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_last[i] = 7'h7F; m_run[i] = 0; m_first[i] = 1'b1;
            m_val[i] = 0; m_vld[i] = 0; m_err[i] = 0; m_chg[i] = 0; m_cnt[i] = 0;
         end else begin
            m_chg[i] = 0;
            if (sample_en) begin
               if (seg_in != m_last[i]) begin
                  m_last[i] = seg_in;
                  m_run[i]  = 0;
               end
               m_run[i]++;
               m_vld[i] = (m_run[i] >= need[i]) && (glyph_index(m_last[i]) >= 0);
               m_err[i] = (m_run[i] >= need[i]) && (glyph_index(m_last[i]) < 0);
               if (m_run[i] == need[i] && glyph_index(m_last[i]) >= 0) begin
                  if (m_first[i] || glyph_index(m_last[i]) != m_val[i]) begin
                     m_chg[i] = 1;
                     m_cnt[i] = (m_cnt[i] + 1) % 256;
                  end
                  m_val[i]   = glyph_index(m_last[i]);
                  m_first[i] = 0;
               end
            end
         end
      end
      if (reset) armed = 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (armed) begin
         check("d0.value",   int'(value0),   m_val[0]);
         check("d0.valid",   int'(valid0),   int'(m_vld[0]));
         check("d0.error",   int'(error0),   int'(m_err[0]));
         check("d0.changed", int'(changed0), int'(m_chg[0]));
         check("d0.count",   int'(count0),   m_cnt[0]);
         check("d1.value",   int'(value1),   m_val[1]);
         check("d1.valid",   int'(valid1),   int'(m_vld[1]));
         check("d1.error",   int'(error1),   int'(m_err[1]));
         check("d1.changed", int'(changed1), int'(m_chg[1]));
         check("d1.count",   int'(count1),   m_cnt[1]);
      end
   end

   // Apply inputs for one clock, return just after the following falling edge.
   task automatic cyc(input logic rst, input logic en, input logic [6:0] s);
      reset = rst; sample_en = en; seg_in = s;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic hold(input logic [6:0] s, input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, s);
   endtask

   initial begin
      @(negedge clock);
      cyc(1'b1, 1'b0, 7'h7F);
      cyc(1'b1, 1'b0, 7'h7F);
      check("reset.value", int'(value0), 0);
      check("reset.valid", int'(valid0), 0);
      check("reset.count", int'(count0), 0);

      // First lock of digit 2
      hold(7'h24, 3);
      check("t1.valid_early", int'(valid0), 0);
      hold(7'h24, 1);
      check("t1.valid",   int'(valid0),   1);
      check("t1.value",   int'(value0),   2);
      check("t1.changed", int'(changed0), 1);
      check("t1.count",   int'(count0),   1);
      hold(7'h24, 1);
      check("t1.pulse_end", int'(changed0), 0);

      // Short glitch to 3 must not be accepted
      hold(7'h30, 2);
      check("t2.glitch_valid", int'(valid0), 0);
      check("t2.glitch_value", int'(value0), 2);
      hold(7'h24, 4);
      check("t2.relock_valid", int'(valid0), 1);
      check("t2.relock_count", int'(count0), 1);

      // Blank is illegal; returning to the same digit is not a change
      hold(7'h10, 4);
      check("t4.value9", int'(value0), 9);
      hold(7'h7F, 4);
      check("t4.error", int'(error0), 1);
      check("t4.valid", int'(valid0), 0);
      check("t4.value", int'(value0), 9);
      hold(7'h10, 4);
      check("t4.error_clr", int'(error0),   0);
      check("t4.valid_back", int'(valid0),  1);
      check("t4.no_change", int'(changed0), 0);
      check("t4.count",     int'(count0),   2);

      // Enable toggling: 4 enabled samples take 7 clocks
      for (int k = 1; k <= 7; k++) begin
         cyc(1'b0, (k % 2) == 1, 7'h12);
         if (k == 6) check("t5.not_yet", int'(valid0), 0);
      end
      check("t5.valid", int'(valid0), 1);
      check("t5.value", int'(value0), 5);

      // Reset while locked at A with five changes counted
      cyc(1'b1, 1'b0, 7'h7F);
      hold(7'h79, 4); hold(7'h24, 4); hold(7'h30, 4); hold(7'h19, 4); hold(7'h08, 4);
      check("t6.value_a", int'(value0), 10);
      check("t6.count5",  int'(count0), 5);
      cyc(1'b1, 1'b1, 7'h08);
      check("t6.rst_value", int'(value0), 0);
      check("t6.rst_valid", int'(valid0), 0);
      check("t6.rst_count", int'(count0), 0);
      hold(7'h79, 1);
      check("t6.n1_valid",   int'(valid1),   1);
      check("t6.n1_value",   int'(value1),   1);
      check("t6.n1_changed", int'(changed1), 1);
      check("t6.n4_valid",   int'(valid0),   0);

      // Walk all glyphs 16 times: 256 changes wrap the 8-bit counter
      cyc(1'b1, 1'b0, 7'h7F);
      for (int r = 0; r < 16; r++) begin
         for (int g = 0; g < 16; g++) hold(glyph[g], 4);
         if (r == 0) begin
            check("t3.walk_value", int'(value0), 15);
            check("t3.walk_count", int'(count0), 16);
         end
      end
      check("t3.wrap_count", int'(count0), 0);
      check("t3.wrap_value", int'(value0), 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
